// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared definitions for the BCD-to-binary converter: FSM
//                state encoding, default digit count and the binary width
//                derived from the digit count.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

   // Default number of BCD digits per conversion request
   localparam int NDIG_DEF = 4;

   // Digit counter width; wide enough for NDIG up to 8
   localparam int CNT_W = 4;

   // Converter states, binary encoded
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Binary width needed to hold any NDIG-digit decimal value:
   // ceil(log2(10^ndig)), e.g. 14 for 4 digits
   function automatic int calc_w(input int ndig);
      longint p;
      int     w;
      p = 1;
      w = 0;
      for (int i = 0; i < ndig; i++) p = p * 10;
      for (int i = 0; i < 40; i++) begin
         if ((longint'(1) << i) < p) w = i + 1;
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mac10.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mac10
//  Description : Combinational multiply-by-ten-and-add step of the decimal
//                to binary conversion; also flags a non-decimal digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_mac10 #(
   parameter int W = 14
) (
   input  logic [W-1:0] acc_i,
   input  logic [3:0]   digit_i,
   output logic [W-1:0] acc_o,
   output logic         bad_o
);

   logic [W+3:0] w_ext;
   logic [W+3:0] w_sum;
   logic [3:0]   w_unused_hi;

   // acc*10 built from two shifts at W+4 bits, then truncated back to W
   always_comb begin
      w_ext       = {4'b0000, acc_i};
      w_sum       = (w_ext << 3) + (w_ext << 1) + {{W{1'b0}}, digit_i};
      acc_o       = w_sum[W-1:0];
      w_unused_hi = w_sum[W+3:W];
      bad_o       = (digit_i > 4'd9);
   end

endmodule
`default_nettype wire

// File: rtl/bcd2bin.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2bin
//  Description : Sequential packed-BCD to binary converter. One digit is
//                folded into the accumulator per clock, MSD first; the
//                result and an invalid-digit flag are held until the next
//                accepted request.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd2bin
   import bcd_pkg::*;
#(
   parameter int NDIG = NDIG_DEF,
   parameter int W    = calc_w(NDIG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [4*NDIG-1:0] bcd,
   output logic            busy,
   output logic            done,
   output logic [W-1:0]    bin,
   output logic            err
);

   state_t             state_q, state_d;
   logic [4*NDIG-1:0]  bcd_q, bcd_d;     // latched digits, shifted MSD-first
   logic [W-1:0]       acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]       bin_q, bin_d;
   logic               err_q, err_d;
   logic               erracc_q, erracc_d; // any bad digit seen so far

   logic [W-1:0]       w_mac_acc;
   logic               w_mac_bad;
   logic               w_err_final;

   // Current digit is always the top nibble of the shifting digit register
   bcd_mac10 #(
      .W       (W)
   ) u_mac (
      .acc_i   (acc_q),
      .digit_i (bcd_q[4*NDIG-1 -: 4]),
      .acc_o   (w_mac_acc),
      .bad_o   (w_mac_bad)
   );

   // State and datapath registers; reset wins over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         bcd_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         bin_q    <= '0;
         err_q    <= 1'b0;
         erracc_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         bcd_q    <= bcd_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
         err_q    <= err_d;
         erracc_q <= erracc_d;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      bcd_d       = bcd_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      bin_d       = bin_q;
      err_d       = err_q;
      erracc_d    = erracc_q;
      w_err_final = erracc_q | w_mac_bad;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               bcd_d    = bcd;
               acc_d    = '0;
               cnt_d    = '0;
               bin_d    = '0;
               err_d    = 1'b0;
               erracc_d = 1'b0;
               state_d  = ST_CONV;
            end
         end
         ST_CONV: begin
            acc_d    = w_mac_acc;
            erracc_d = w_err_final;
            bcd_d    = bcd_q << 4;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NDIG - 1)) begin
               state_d = ST_DONE;
               err_d   = w_err_final;
               bin_d   = w_err_final ? '0 : w_mac_acc;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy = (state_q == ST_CONV);
   assign done = (state_q == ST_DONE);
   assign bin  = bin_q;
   assign err  = err_q;

endmodule
`default_nettype wire
